uart_rx_parity_check: RTL
=========================

Name: uart_rx_parity_check

Overview:
UART receiver for the serial link, paired with the transmit-side even-parity generator. Deserialises 8E1 frames from the rx line, checks even parity over the 8 data bits and validates the stop bit. Presents each byte with a one-cycle valid pulse and per-frame error flags to the downstream consumer.

Parameters:
CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); minimum 4, must be even
CNT_W, 10, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
data_out  output  8  last received byte; held until the next frame completes
data_valid  output  1  one-cycle pulse; data_out, parity_err and frame_err are valid in this cycle
parity_err  output  1  1 = received parity bit != ^data_out (even-parity violation)
frame_err  output  1  1 = stop bit sampled low
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1): data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE, counter=0, bit index=0, both synchroniser flops=1.
- rx passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s.
- Frame format: start(0), D0..D7 LSB first, parity P, stop(1). Even parity: D0^...^D7^P must equal 0, which matches the generator (P = ^data).
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: when rx_s==0, go to START and clear the counter.
- START: count to CLKS_PER_BIT/2-1 (mid-bit). If rx_s==0 at mid-bit, go to DATA with counter=0 and bit index=0. If rx_s==1, treat as a glitch and return to IDLE with no outputs.
- DATA: count to CLKS_PER_BIT-1 and sample. The shift register shifts right with rx_s entering at bit 7. After the 8th sample (bit index 7), go to PARITY.
- PARITY: sample at the next mid-bit and latch p_bad = (^shift_reg) ^ rx_s. Go to STOP.
- STOP: sample at the next mid-bit. In the following cycle:
  - data_out <= shift_reg, parity_err <= p_bad, frame_err <= ~rx_s, data_valid=1 for exactly one cycle.
  - If rx_s==1, go to IDLE; otherwise go to WAIT_HIGH.
- WAIT_HIGH (break or framing loss): stay until rx_s==1, then go to IDLE. No new frame is accepted while in this state.
- Error flags and data_out are updated only on data_valid. They are sticky until the next data_valid, and they are updated even when errors are present.
- Latency: data_valid rises 1 clk after the stop-bit mid sample, about 2 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT clks after the rx falling edge.
- Back-to-back frames: the receiver re-arms in IDLE at mid-stop-bit, so a start bit immediately following the stop bit is detected with no lost frame.
- rx activity while busy is ignored except at sample points.
- Reset asserted mid-frame aborts immediately with no data_valid. Receive resumes at the next falling edge after reset release.
- The counter never wraps. It is cleared on every sample point and on every state transition.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: 8E1 frame as above, including the PARITY state.
- Undefined: 8N1 frame. The PARITY state is removed and DATA goes directly to STOP. parity_err is tied to 0, and the STOP sample point moves one bit period earlier.
- Defined is the default build. The TX side must be built with the matching setting.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 with P=0 and stop=1 -> data_valid pulses once, data_out=0xA5, parity_err=0, frame_err=0, busy low afterwards.
- Send 0x07 with P=0 (wrong; correct is 1) -> data_out=0x07, parity_err=1, frame_err=0.
- Send 0x3C, P=0, stop=0, then hold rx low for 3 bit periods -> data_valid with frame_err=1; FSM stays in WAIT_HIGH; no second data_valid until rx returns high and a new frame is sent.
- 6-clk low glitch on idle rx -> no data_valid; state returns to IDLE; busy pulses only during START.
- Back-to-back frames 0x55 then 0xFF with zero idle gap -> two data_valid pulses, 0x55 then 0xFF, both error-free.
- Assert rst during D4 of a frame, release, then send 0x81 with P=0 -> no output for the aborted frame; next data_valid shows 0x81 with no errors; all outputs are 0 while rst is asserted.

Source files
------------

// File: rtl/uart_rx_parity_check.sv
// rtl/uart_rx_parity_check.sv - UART receiver with even-parity and stop-bit checking
//
// Deserialises frames from the asynchronous rx line: start(0), D0..D7 LSB
// first, optional even-parity bit, stop(1). Each completed frame is presented
// with a one-cycle data_valid pulse together with its error flags.
//
// Build option: UART_RX_PARITY_EN
//   defined   -> 8E1 frames, parity bit checked (PARITY state present)
//   undefined -> 8N1 frames, no parity bit, parity_err tied low
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   rx         serial line, idle high, asynchronous to clk
//   data_out   last received byte, held until the next frame completes
//   data_valid one-cycle pulse; data_out/parity_err/frame_err valid here
//   parity_err received parity bit disagrees with even parity over data
//   frame_err  stop bit sampled low
//   busy       receiver is not idle

module uart_rx_parity_check #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  // Last count of the half-bit (start-bit centring) and full-bit intervals.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state;
  state_t           state_next;
  logic             rx_m;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             data_tick;
  logic             frame_done;
  logic             cnt_clr;
`ifdef UART_RX_PARITY_EN
  logic             parity_tick;
  logic             p_bad;
`endif

  // Two-flop synchroniser; resets to the idle (high) line level so that
  // reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    data_tick  = 1'b0;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_tick = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (cnt == HALF_LAST) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          data_tick = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state_next = PARITY;
`else
          if (bit_idx == 3'd7) state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == FULL_LAST) begin
          parity_tick = 1'b1;
          state_next  = STOP;
        end
      end
`endif
      STOP: begin
        // Re-arm at mid stop bit so a start bit right after it is not lost.
        if (cnt == FULL_LAST) begin
          frame_done = 1'b1;
          state_next = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // The bit counter restarts at every sample point and every state change,
    // so it never has to wrap.
    cnt_clr = data_tick || (state_next != state);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= frame_done;

      if (cnt_clr)
        cnt <= '0;
      else if (state != IDLE && state != WAIT_HIGH)
        cnt <= cnt + 1'b1;

      if (state == START)
        bit_idx <= 3'd0;
      else if (data_tick)
        bit_idx <= bit_idx + 3'd1;

      // LSB arrives first, so shift right with the new bit entering at the top.
      if (data_tick)
        shift_reg <= {rx_s, shift_reg[7:1]};

      if (frame_done) begin
        data_out  <= shift_reg;
        frame_err <= ~rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_bad      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (parity_tick)
        p_bad <= (^shift_reg) ^ rx_s;
      if (frame_done)
        parity_err <= p_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule
